// File: rtl/sega_joy_pkg.sv
// Shared types and constants for the Sega joystick scan controller.
// Contents:
//   state_t     - sequencer FSM states
//   pad_type_t  - pad classification reported to the host
//   BTN_*       - bit positions inside the 12-bit active-high button word
//   PIN_*       - bit positions of the 6 active-low connector pins
//   PH_*        - SEL phases in which the decoder captures something
package sega_joy_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_COMMIT
  } state_t;

  typedef enum logic [1:0] {
    PAD_NONE = 2'b00,
    PAD_3BTN = 2'b01,
    PAD_6BTN = 2'b10
  } pad_type_t;

  localparam int BTN_W     = 12;
  localparam int PIN_W     = 6;

  localparam int BTN_UP    = 0;
  localparam int BTN_DN    = 1;
  localparam int BTN_LT    = 2;
  localparam int BTN_RT    = 3;
  localparam int BTN_B     = 4;
  localparam int BTN_C     = 5;
  localparam int BTN_A     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_Z     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_X     = 10;
  localparam int BTN_MODE  = 11;

  localparam int PIN_UP    = 0;
  localparam int PIN_DN    = 1;
  localparam int PIN_LT    = 2;
  localparam int PIN_RT    = 3;
  localparam int PIN_BA    = 4;  // B with SEL high, A with SEL low
  localparam int PIN_CS    = 5;  // C with SEL high, START with SEL low

  localparam logic [2:0] PH_BASE = 3'd0;  // SEL high: d-pad, B, C
  localparam logic [2:0] PH_ID   = 3'd1;  // SEL low: LT/RT low => connected, A, START
  localparam logic [2:0] PH_SIX  = 3'd5;  // SEL low: all d-pad low => 6-button
  localparam logic [2:0] PH_EXT  = 3'd6;  // SEL high: Z, Y, X, MODE

endpackage

// File: rtl/sega_pad_decoder.sv
// Per-pad input path and classifier.
// Synchronizes the raw connector pins, captures the pin states in the scan
// phases that carry information, and presents the status word and pad type
// that the sequencer loads at commit time.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   pins          - raw active-low connector pins (asynchronous)
//   phase         - current SEL phase 0..7
//   sample        - strobe on the last cycle of a phase
//   scan_start    - strobe on the cycle a scan begins
//   status_nxt    - 12-bit active-high button word for the next commit
//   type_nxt      - pad classification for the next commit
module sega_pad_decoder
  import sega_joy_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PIN_W-1:0] pins,
  input  logic [2:0]       phase,
  input  logic             sample,
  input  logic             scan_start,
  output logic [BTN_W-1:0] status_nxt,
  output pad_type_t        type_nxt
);

  logic [PIN_W-1:0] sync1_q, sync2_q;
  logic [BTN_W-1:0] shadow_q, shadow_d;
  logic             conn_q, conn_d;
  logic             six_q, six_d;
  logic [PIN_W-1:0] p;

  // Pins are asynchronous to clk; two flops before anything looks at them.
  // NOTE: every flop here is reset, including the shadow word; the
  // synchronizer resets to all-ones, which reads as "pins released".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      shadow_q <= '0;
      conn_q   <= 1'b0;
      six_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1_q  <= pins;
      sync2_q  <= sync1_q;
      shadow_q <= shadow_d;
      conn_q   <= conn_d;
      six_q    <= six_d;
    end
  end

  assign p = ~sync2_q;

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    shadow_d = shadow_q;
    conn_d   = conn_q;
    six_d    = six_q;
    if (scan_start) begin
      // Forget last scan's detection so an unplugged pad reads as none.
      conn_d = 1'b0;
      six_d  = 1'b0;
    end else if (sample) begin
      case (phase)
        PH_BASE: shadow_d[5:0] = p;
        PH_ID: begin
          conn_d              = p[PIN_LT] & p[PIN_RT];
          shadow_d[BTN_A]     = p[PIN_BA];
          shadow_d[BTN_START] = p[PIN_CS];
        end
        PH_SIX:  six_d = p[PIN_UP] & p[PIN_DN] & p[PIN_LT] & p[PIN_RT];
        PH_EXT:  shadow_d[11:8] = p[3:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    status_nxt = '0;
    type_nxt   = PAD_NONE;
    if (conn_q) begin
      if (six_q) begin
        status_nxt = shadow_q;
        type_nxt   = PAD_6BTN;
      end else begin
        status_nxt = {4'b0, shadow_q[7:0]};
        type_nxt   = PAD_3BTN;
      end
    end
  end

endmodule

// File: rtl/sega_pad_sequencer.sv
// Scan controller for the two Sega joystick ports.
// Idles with SEL high, then steps SEL through the 8-phase (or 2-phase)
// protocol, and commits both pads' status and type in one cycle.
// A host read in progress (freeze) defers the commit, never the scan.
// Ports:
//   clk, reset_n     - clock, asynchronous active-low reset
//   sj1, sj2         - raw active-low pad pins
//   freeze           - hold published status while the host reads
//   sj1_sel, sj2_sel - SEL to both pads (identical)
//   status1, status2 - active-high button words
//   type1, type2     - pad type: 00 none, 01 3-button, 10 6-button
//   scan_done        - one-cycle pulse when new status is published
module sega_pad_sequencer
  import sega_joy_pkg::*;
#(
  parameter int PHASE_CYCLES = 100,
  parameter int IDLE_CYCLES  = 100000,
  parameter int SIX_BTN_EN   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PIN_W-1:0] sj1,
  input  logic [PIN_W-1:0] sj2,
  input  logic             freeze,
  output logic             sj1_sel,
  output logic             sj2_sel,
  output logic [BTN_W-1:0] status1,
  output logic [BTN_W-1:0] status2,
  output logic [1:0]       type1,
  output logic [1:0]       type2,
  output logic             scan_done
);

  localparam int CNT_MAX = (IDLE_CYCLES > PHASE_CYCLES) ? IDLE_CYCLES : PHASE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD  = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [2:0]       LAST_PHASE = (SIX_BTN_EN != 0) ? 3'd7 : 3'd1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;  // idle countdown or phase countdown
  logic [2:0]       phase_q, phase_d;
  logic             sel_q, sel_d;
  logic [BTN_W-1:0] status1_q, status1_d, status2_q, status2_d;
  pad_type_t        type1_q, type1_d, type2_q, type2_d;
  logic             scan_done_q, scan_done_d;

  logic             sample, scan_start;
  logic [BTN_W-1:0] nxt_status1, nxt_status2;
  pad_type_t        nxt_type1, nxt_type2;

  sega_pad_decoder u_pad1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .pins       (sj1),
    .phase      (phase_q),
    .sample     (sample),
    .scan_start (scan_start),
    .status_nxt (nxt_status1),
    .type_nxt   (nxt_type1)
  );

  sega_pad_decoder u_pad2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .pins       (sj2),
    .phase      (phase_q),
    .sample     (sample),
    .scan_start (scan_start),
    .status_nxt (nxt_status2),
    .type_nxt   (nxt_type2)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= IDLE_LOAD;
      phase_q     <= 3'd0;
      sel_q       <= 1'b1;
      status1_q   <= '0;
      status2_q   <= '0;
      type1_q     <= PAD_NONE;
      type2_q     <= PAD_NONE;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      sel_q       <= sel_d;
      status1_q   <= status1_d;
      status2_q   <= status2_d;
      type1_q     <= type1_d;
      type2_q     <= type2_d;
      scan_done_q <= scan_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    sel_d       = sel_q;
    status1_d   = status1_q;
    status2_d   = status2_q;
    type1_d     = type1_q;
    type2_d     = type2_q;
    scan_done_d = 1'b0;
    sample      = 1'b0;
    scan_start  = 1'b0;

    case (state_q)
      S_IDLE: begin
        sel_d = 1'b1;
        if (cnt_q == '0) begin
          state_d    = S_SCAN;
          phase_d    = 3'd0;
          cnt_d      = PHASE_LOAD;
          scan_start = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SCAN: begin
        if (cnt_q == '0) begin
          sample = 1'b1;
          if (phase_q == LAST_PHASE) begin
            state_d = S_COMMIT;
            sel_d   = 1'b1;
          end else begin
            phase_d = phase_q + 3'd1;
            // SEL is high in even phases; the next phase is even when this one is odd.
            sel_d   = phase_q[0];
            cnt_d   = PHASE_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_COMMIT: begin
        sel_d = 1'b1;
        if (!freeze) begin
          status1_d   = nxt_status1;
          status2_d   = nxt_status2;
          type1_d     = nxt_type1;
          type2_d     = nxt_type2;
          scan_done_d = 1'b1;
          state_d     = S_IDLE;
          cnt_d       = IDLE_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = IDLE_LOAD;
        sel_d   = 1'b1;
      end
    endcase
  end

  assign sj1_sel   = sel_q;
  assign sj2_sel   = sel_q;
  assign status1   = status1_q;
  assign status2   = status2_q;
  assign type1     = type1_q;
  assign type2     = type2_q;
  assign scan_done = scan_done_q;

endmodule

// File: tb/tb_sega_pad_sequencer.sv
// Bench for sega_pad_sequencer with PHASE_CYCLES = 4, IDLE_CYCLES = 16.
// A second instance runs with SIX_BTN_EN = 0 against a 6-button pad holding Z.
// Pad models respond to SEL like real 3/6-button controllers; cycle n is the
// n-th rising edge since reset release, sampled on the following falling edge.
module tb_sega_pad_sequencer;
  import sega_joy_pkg::*;

  typedef struct {
    int          cyc;
    logic [11:0] s1;
    logic [1:0]  t1;
    logic [11:0] s2;
    logic [1:0]  t2;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        freeze;
  logic        freeze_b = 1'b0;
  logic [5:0]  sj1, sj2, sj1b, sj2b;
  logic        sel1, sel2, sel1b, sel2b;
  logic [11:0] st1, st2, st1b, st2b;
  logic [1:0]  ty1, ty2, ty1b, ty2b;
  logic        done, done_b;

  int          kind1, kind2;
  logic [11:0] btn1, btn2;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc;
  exp_t sb[$];

  sega_pad_sequencer #(.PHASE_CYCLES(4), .IDLE_CYCLES(16), .SIX_BTN_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .sj1(sj1), .sj2(sj2), .freeze(freeze),
    .sj1_sel(sel1), .sj2_sel(sel2), .status1(st1), .status2(st2),
    .type1(ty1), .type2(ty2), .scan_done(done)
  );

  sega_pad_sequencer #(.PHASE_CYCLES(4), .IDLE_CYCLES(16), .SIX_BTN_EN(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .sj1(sj1b), .sj2(sj2b), .freeze(freeze_b),
    .sj1_sel(sel1b), .sj2_sel(sel2b), .status1(st1b), .status2(st2b),
    .type1(ty1b), .type2(ty2b), .scan_done(done_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pad model: kind 0 = absent, 3 = 3-button, 6 = 6-button. fc counts SEL
  // falling edges since the pad's idle timeout.
  function automatic logic [5:0] pad_pins(input int kind, input logic [11:0] b,
                                          input logic sel, input int fc);
    logic [5:0] pr;
    pr = '0;
    if (kind == 0) return 6'h3F;
    if (sel) begin
      if (kind == 6 && fc == 3) pr = {b[BTN_C], b[BTN_B], b[BTN_MODE], b[BTN_X], b[BTN_Y], b[BTN_Z]};
      else                      pr = b[5:0];
    end else begin
      if (kind == 6 && fc == 3) pr = {b[BTN_START], b[BTN_A], 4'b1111};
      else                      pr = {b[BTN_START], b[BTN_A], 2'b11, b[BTN_DN], b[BTN_UP]};
    end
    return ~pr;
  endfunction

  logic sel_prev   = 1'b1;
  logic sel_prev_b = 1'b1;
  int   hi_run = 0,   fall_cnt = 0;
  int   hi_run_b = 0, fall_cnt_b = 0;

  always @(posedge clk) begin
    sel_prev <= sel1;
    if (!sel1) hi_run <= 0; else if (hi_run < 100) hi_run <= hi_run + 1;
    if (sel_prev && !sel1) fall_cnt <= fall_cnt + 1;
    else if (hi_run >= 8)  fall_cnt <= 0;
  end

  always @(posedge clk) begin
    sel_prev_b <= sel1b;
    if (!sel1b) hi_run_b <= 0; else if (hi_run_b < 100) hi_run_b <= hi_run_b + 1;
    if (sel_prev_b && !sel1b) fall_cnt_b <= fall_cnt_b + 1;
    else if (hi_run_b >= 8)   fall_cnt_b <= 0;
  end

  always_comb begin
    sj1  = pad_pins(kind1, btn1, sel1, fall_cnt);
    sj2  = pad_pins(kind2, btn2, sel2, fall_cnt);
    sj1b = pad_pins(6, 12'h100, sel1b, fall_cnt_b);
    sj2b = 6'h3F;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  logic sel_neq = 1'b0;
  always @(negedge clk) if (sel1 !== sel2) sel_neq <= 1'b1;

  // Scoreboard monitor for the 6-button-enabled instance.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_scan_done: pulse at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("status1", st1, e.s1);
        check("type1", ty1, e.t1);
        check("status2", st2, e.s2);
        check("type2", ty2, e.t2);
      end
    end
  end

  // Monitor for the 2-phase instance: commits every 25 cycles, pad 1 reads
  // as a 3-button pad with Z invisible, pad 2 absent.
  int next_b   = 25;
  int pulses_b = 0;
  always @(negedge clk) begin
    if (!reset_n) next_b <= 25;
    else if (done_b) begin
      check("b_cycle", cyc, next_b);
      check("b_status1", st1b, 32'h0);
      check("b_type1", ty1b, PAD_3BTN);
      check("b_status2", st2b, 32'h0);
      check("b_type2", ty2b, PAD_NONE);
      next_b   <= next_b + 25;
      pulses_b <= pulses_b + 1;
    end
  end

  task automatic wait_cyc(input int c);
    int guard = 0;
    while (cyc != c && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != c) check("wait_cyc_timeout", cyc, c);
  endtask

  function automatic exp_t mk(input int c, input logic [11:0] s1, input logic [1:0] t1,
                              input logic [11:0] s2, input logic [1:0] t2);
    exp_t e;
    e.cyc = c; e.s1 = s1; e.t1 = t1; e.s2 = s2; e.t2 = t2;
    return e;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; freeze = 1'b0;
    kind1 = 0; kind2 = 0; btn1 = '0; btn2 = '0;
    repeat (3) @(negedge clk);
    check("rst_sel", sel1, 1);
    check("rst_status1", st1, 0);
    check("rst_status2", st2, 0);
    check("rst_type1", ty1, 0);
    check("rst_type2", ty2, 0);
    check("rst_done", done, 0);

    // Scan 1: no pads; check the full SEL waveform.
    sb.push_back(mk(49, 12'h000, PAD_NONE, 12'h000, PAD_NONE));
    reset_n = 1'b1;
    for (int c = 0; c <= 48; c++) begin
      logic exp_sel;
      wait_cyc(c);
      if (c < 16 || c == 48) exp_sel = 1'b1;
      else                   exp_sel = (((c - 16) / 4) % 2) == 0;
      check("sel_pattern", sel1, exp_sel);
    end

    // Scan 2: pad 1 3-button with A+UP.
    wait_cyc(50);
    kind1 = 3; btn1 = 12'h041;
    sb.push_back(mk(98, 12'h041, PAD_3BTN, 12'h000, PAD_NONE));

    // Scan 3: pad 1 6-button X+START, pad 2 3-button C.
    wait_cyc(99);
    kind1 = 6; btn1 = 12'h480; kind2 = 3; btn2 = 12'h020;
    sb.push_back(mk(147, 12'h480, PAD_6BTN, 12'h020, PAD_3BTN));

    // Scan 4: pad 1 3-button B, pad 2 unplugged; commit deferred by freeze.
    wait_cyc(148);
    kind1 = 3; btn1 = 12'h010; kind2 = 0; btn2 = '0;
    sb.push_back(mk(207, 12'h010, PAD_3BTN, 12'h000, PAD_NONE));
    wait_cyc(187);
    freeze = 1'b1;
    wait_cyc(202);
    check("frozen_status1", st1, 12'h480);
    check("frozen_type1", ty1, PAD_6BTN);
    check("frozen_status2", st2, 12'h020);
    wait_cyc(206);
    freeze = 1'b0;

    // Scan 5 restarts a full idle period after the deferred commit.
    sb.push_back(mk(256, 12'h010, PAD_3BTN, 12'h000, PAD_NONE));
    wait_cyc(226);
    check("post_freeze_phase0_sel", sel1, 1);
    wait_cyc(227);
    check("post_freeze_phase1_sel", sel1, 0);

    // Scan 6 is cut by reset during phase 3 (cycles 284..287).
    wait_cyc(257);
    kind1 = 0; btn1 = '0; kind2 = 6; btn2 = 12'hA00;
    wait_cyc(285);
    check("phase3_sel_low", sel1, 0);
    #2 reset_n = 1'b0;
    #1;
    check("midscan_rst_sel", sel1, 1);
    check("midscan_rst_status1", st1, 0);
    check("midscan_rst_type1", ty1, 0);
    check("midscan_rst_status2", st2, 0);
    check("midscan_rst_done", done, 0);
    repeat (2) @(negedge clk);
    sb.push_back(mk(49, 12'h000, PAD_NONE, 12'hA00, PAD_6BTN));
    reset_n = 1'b1;
    wait_cyc(19);
    check("post_rst_phase0_sel", sel1, 1);
    wait_cyc(20);
    check("post_rst_phase1_sel", sel1, 0);

    wait_cyc(60);
    check("scoreboard_drained", sb.size(), 0);
    check("b_pulse_count", pulses_b, 13);
    check("sel_lines_equal", sel_neq, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
